// File: rtl/fir_4tap_deconv.sv
// Sequential deconvolver for the 4-tap FIR: one shared MAC, 5 cycles per sample.
// Optional FIR_DECONV_ERRCNT_EN adds a saturating 8-bit error counter output.
module fir_4tap_deconv #(
    parameter logic signed [7:0] H0       = -8'sd2,
    parameter int unsigned       H0_SHIFT = 1,
    parameter logic signed [7:0] H1       = -8'sd1,
    parameter logic signed [7:0] H2       = 8'sd3,
    parameter logic signed [7:0] H3       = 8'sd4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] Yin,
    input  logic        yin_valid,
    output logic        yin_ready,
    output logic [7:0]  Xout,
    output logic        xout_valid,
    output logic        err_exact,
    output logic        err_range,
    output logic        err_sticky
`ifdef FIR_DECONV_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    typedef enum logic [2:0] {IDLE, MAC1, MAC2, MAC3, DIV} state_t;

    localparam logic [19:0] REM_MASK = 20'((1 << H0_SHIFT) - 1);

    state_t             state, state_next;
    logic signed [19:0] acc;
    logic signed [7:0]  x1, x2, x3;
    logic signed [7:0]  coef, hist;
    logic signed [15:0] prod;
    logic signed [19:0] mac;
    logic signed [19:0] q_shift;
    logic signed [20:0] q;
    logic signed [7:0]  q_sat;
    logic               rem_nz;
    logic               out_of_range;

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (yin_valid) state_next = MAC1;
            MAC1:    state_next = MAC2;
            MAC2:    state_next = MAC3;
            MAC3:    state_next = DIV;
            DIV:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign yin_ready = (state == IDLE);

    // Single multiplier: coefficient and history operand selected by MAC step.
    always_comb begin
        coef = '0;
        hist = '0;
        case (state)
            MAC1: begin coef = H1; hist = x1; end
            MAC2: begin coef = H2; hist = x2; end
            MAC3: begin coef = H3; hist = x3; end
            default: begin coef = '0; hist = '0; end
        endcase
    end

    assign prod = coef * hist;
    assign mac  = acc - $signed({{4{prod[15]}}, prod});

    // Floor shift first, then sign correction for a negative H0.
    always_comb begin
        q_shift      = acc >>> H0_SHIFT;
        q            = (H0 < 0) ? -21'(q_shift) : 21'(q_shift);
        out_of_range = (q > 21'sd127) || (q < -21'sd128);
        if (q > 21'sd127)       q_sat = 8'sd127;
        else if (q < -21'sd128) q_sat = -8'sd128;
        else                    q_sat = q[7:0];
        rem_nz       = |(acc & REM_MASK);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc        <= '0;
            x1         <= '0;
            x2         <= '0;
            x3         <= '0;
            Xout       <= '0;
            xout_valid <= 1'b0;
            err_exact  <= 1'b0;
            err_range  <= 1'b0;
            err_sticky <= 1'b0;
`ifdef FIR_DECONV_ERRCNT_EN
            err_count  <= '0;
`endif
        end else begin
            xout_valid <= 1'b0;
            err_exact  <= 1'b0;
            err_range  <= 1'b0;
            case (state)
                IDLE: if (yin_valid) acc <= $signed({{4{Yin[15]}}, Yin});
                MAC1, MAC2, MAC3: acc <= mac;
                DIV: begin
                    Xout       <= q_sat;
                    xout_valid <= 1'b1;
                    err_exact  <= rem_nz;
                    err_range  <= out_of_range;
                    err_sticky <= err_sticky | rem_nz | out_of_range;
                    x3         <= x2;
                    x2         <= x1;
                    x1         <= q_sat;
`ifdef FIR_DECONV_ERRCNT_EN
                    if ((rem_nz || out_of_range) && (err_count != 8'hFF))
                        err_count <= err_count + 8'd1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_4tap_deconv.sv
// Self-checking bench for fir_4tap_deconv against an arithmetic reference model.
// Build with FIR_DECONV_ERRCNT_EN to also exercise the error counter.
module tb_fir_4tap_deconv;

    localparam int C0 = -2;
    localparam int SH = 1;
    localparam int C1 = -1;
    localparam int C2 = 3;
    localparam int C3 = 4;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [15:0] Yin = '0;
    logic        yin_valid = 1'b0;
    logic        yin_ready;
    logic [7:0]  Xout;
    logic        xout_valid;
    logic        err_exact;
    logic        err_range;
    logic        err_sticky;
`ifdef FIR_DECONV_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int tests  = 0;
    int failed = 0;

    // reference model state
    int mx1, mx2, mx3, msticky, mcount;
    // forward-FIR history for round-trip stimulus
    int tx1, tx2, tx3;

    fir_4tap_deconv #(
        .H0(8'(C0)), .H0_SHIFT(SH), .H1(8'(C1)), .H2(8'(C2)), .H3(8'(C3))
    ) dut (
        .Clk(Clk), .Rst(Rst), .Yin(Yin), .yin_valid(yin_valid), .yin_ready(yin_ready),
        .Xout(Xout), .xout_valid(xout_valid), .err_exact(err_exact),
        .err_range(err_range), .err_sticky(err_sticky)
`ifdef FIR_DECONV_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mx1 = 0; mx2 = 0; mx3 = 0; msticky = 0; mcount = 0;
        tx1 = 0; tx2 = 0; tx3 = 0;
    endtask

    // x = (y - H1 x1 - H2 x2 - H3 x3) / H0 with floor division by |H0|
    task automatic model_step(input int y, output int xo, output int ee, output int er);
        int a, d, r, qf, qq;
        a  = y - C1 * mx1 - C2 * mx2 - C3 * mx3;
        d  = 1 << SH;
        r  = a % d;
        if (r < 0) r += d;
        qf = (a - r) / d;
        qq = (C0 < 0) ? -qf : qf;
        ee = (r != 0) ? 1 : 0;
        er = (qq > 127 || qq < -128) ? 1 : 0;
        xo = (qq > 127) ? 127 : (qq < -128) ? -128 : qq;
        mx3 = mx2; mx2 = mx1; mx1 = xo;
        if (ee != 0 || er != 0) begin
            msticky = 1;
            if (mcount < 255) mcount++;
        end
    endtask

    task automatic reset_dut();
        Rst = 1'b1; yin_valid = 1'b0; Yin = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        model_clear();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_xout"}, $signed(Xout), 0);
        chk({tag, "_xvalid"}, xout_valid, 0);
        chk({tag, "_eexact"}, err_exact, 0);
        chk({tag, "_erange"}, err_range, 0);
        chk({tag, "_sticky"}, err_sticky, 0);
        chk({tag, "_ready"}, yin_ready, 1);
`ifdef FIR_DECONV_ERRCNT_EN
        chk({tag, "_count"}, err_count, 0);
`endif
    endtask

    task automatic decode(input string tag, input int y, output int xo);
        int j, ee, er;
        @(negedge Clk);
        j = 0;
        while (!yin_ready && j < 20) begin @(negedge Clk); j++; end
        Yin = 16'(y); yin_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        yin_valid = 1'b0;
        j = 0;
        while (!xout_valid && j < 10) begin @(negedge Clk); j++; end
        model_step(y, xo, ee, er);
        chk({tag, "_latency"}, j, 4);
        chk({tag, "_xout"}, $signed(Xout), xo);
        chk({tag, "_eexact"}, err_exact, ee);
        chk({tag, "_erange"}, err_range, er);
        chk({tag, "_sticky"}, err_sticky, msticky);
    endtask

    initial begin
        int xo, ee, er, x, y;

        // reset state
        reset_dut();
        check_idle_outputs("reset");

        // directed decode sequence
        begin
            int ys[5] = '{6, 1, -10, -5, 8};
            int xs[5] = '{-3, 1, 0, -2, -1};
            for (int i = 0; i < 5; i++) begin
                decode("seq", ys[i], xo);
                chk("seq_const", $signed(Xout), xs[i]);
            end
            chk("seq_clean", err_sticky, 0);
        end

        // handshake: valid held high continuously
        reset_dut();
        Yin = 16'(6); yin_valid = 1'b1;
        for (int i = 0; i <= 15; i++) begin
            if (i > 0) @(negedge Clk);
            if (i == 11) yin_valid = 1'b0;
            chk("hs_ready", yin_ready, (i % 5 == 0) ? 1 : 0);
            chk("hs_xvalid", xout_valid, (i > 0 && i % 5 == 0) ? 1 : 0);
            if (i > 0 && i % 5 == 0) begin
                model_step(6, xo, ee, er);
                chk("hs_xout", $signed(Xout), xo);
                chk("hs_eexact", err_exact, ee);
            end
        end

        // non-exact division, sticky persists
        reset_dut();
        decode("nonexact", 7, xo);
        chk("nonexact_val", $signed(Xout), -3);
        chk("nonexact_flag", err_exact, 1);
        decode("nonexact_next", 1, xo);
        decode("nonexact_next2", 3, xo);
        chk("sticky_hold", err_sticky, 1);

        // saturation, and the saturated value feeds the history
        reset_dut();
        decode("range", -300, xo);
        chk("range_sat", $signed(Xout), 127);
        chk("range_flag", err_range, 1);
        decode("range_next", 0, xo);

        // reset while in MAC2 aborts the sample
        reset_dut();
        @(negedge Clk);
        Yin = 16'(6); yin_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        yin_valid = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check_idle_outputs("midrst");
        Rst = 1'b0;
        model_clear();
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            chk("midrst_novalid", xout_valid, 0);
        end
        decode("midrst_after", 6, xo);
        chk("midrst_val", $signed(Xout), -3);

        // random round-trip through the forward FIR
        reset_dut();
        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(255)) - 128;
            y = C0 * x + C1 * tx1 + C2 * tx2 + C3 * tx3;
            tx3 = tx2; tx2 = tx1; tx1 = x;
            decode("rt", y, xo);
            chk("rt_recover", $signed(Xout), x);
        end

        // random arbitrary samples against the model
        reset_dut();
        for (int i = 0; i < 40; i++) begin
            y = int'($urandom_range(3000)) - 1500;
            decode("rnd", y, xo);
        end

`ifdef FIR_DECONV_ERRCNT_EN
        reset_dut();
        for (int i = 0; i < 300; i++) decode("cnt", 7, xo);
        chk("cnt_model", mcount, 255);
        chk("cnt_sat", err_count, mcount);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
